// File: rtl/qed_pkg.sv
// rtl/qed_pkg.sv - shared types and constants for the QED consistency checker
package qed_pkg;

    // Checker FSM: HALT is terminal until reset
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_HALT = 2'd2
    } qed_state_e;

    localparam logic [1:0] ERR_NONE      = 2'b00;
    localparam logic [1:0] ERR_MISMATCH  = 2'b01;
    localparam logic [1:0] ERR_PARTITION = 2'b10;

    // Registers per half, including the never-written x0/x16 slot
    localparam int QED_HALF_REGS = 16;

    // Bit 4 of a register number selects the duplicate half
    localparam logic DUP_HALF_BIT = 1'b1;

    // Duplicate register that shadows original register r
    function automatic logic [4:0] dup_reg(input logic [4:0] r);
        return {DUP_HALF_BIT, r[3:0]};
    endfunction

endpackage

// File: rtl/qed_shadow_regfile.sv
// rtl/qed_shadow_regfile.sv - shadow copies of both register halves with an indexed pair compare
module qed_shadow_regfile
    import qed_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we_i,
    input  logic            dup_sel_i,
    input  logic [3:0]      widx_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [3:0]      cidx_i,
    output logic            mismatch_o
);

    // Entry 0 does not exist: x0 and x16 never hold architectural state worth comparing
    logic [XLEN-1:0] orig_q [1:QED_HALF_REGS-1];
    logic [XLEN-1:0] dup_q  [1:QED_HALF_REGS-1];

    // Single write port; the half is picked by bit 4 of the destination register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            orig_q <= '{default: '0};
            dup_q  <= '{default: '0};
        end else if (we_i && (widx_i != 4'd0)) begin
            if (dup_sel_i) begin
                dup_q[widx_i] <= wdata_i;
            end else begin
                orig_q[widx_i] <= wdata_i;
            end
        end
    end

    // Pair compare for the scanner; index 0 is never a valid pair
    always_comb begin
        mismatch_o = 1'b0;
        if (cidx_i != 4'd0) begin
            mismatch_o = (orig_q[cidx_i] != dup_q[cidx_i]);
        end
    end

endmodule

// File: rtl/qed_consistency_checker.sv
// rtl/qed_consistency_checker.sv - compares original and duplicate register halves at QED sync points
module qed_consistency_checker
    import qed_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            commit_valid,
    input  logic            commit_is_dup,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            check_en,
    output logic            check_busy,
    output logic            check_pass,
    output logic            qed_error,
    output logic [1:0]      err_code,
    output logic [3:0]      err_idx
);

    logic wr_en;
    logic violation;
    logic mismatch;

    qed_state_e       state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic [CNT_W-1:0] orig_cnt_q, dup_cnt_q;
    logic [CNT_W-1:0] last_chk_q, last_chk_d;
    logic [CNT_W-1:0] prev_chk_q, prev_chk_d;
    logic             pass_q, pass_d;
    logic             err_q, err_d;
    logic [1:0]       err_code_q, err_code_d;
    logic [3:0]       err_idx_q, err_idx_d;

    assign wr_en = commit_valid && wb_we && (wb_rd != 5'd0);

    // x16 is reserved, and each half may only be written by its own instruction stream
    assign violation = wr_en && ((wb_rd == dup_reg(5'd0)) || (wb_rd[4] != commit_is_dup));

    qed_shadow_regfile #(
        .XLEN(XLEN)
    ) u_shadow (
        .clk        (clk),
        .rst_n      (rst_n),
        .we_i       (wr_en),
        .dup_sel_i  (wb_rd[4]),
        .widx_i     (wb_rd[3:0]),
        .wdata_i    (wb_data),
        .cidx_i     (idx_q),
        .mismatch_o (mismatch)
    );

    // Retired-instruction counters per stream; wrap is harmless since only equality matters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            orig_cnt_q <= '0;
            dup_cnt_q  <= '0;
        end else if (commit_valid) begin
            if (commit_is_dup) begin
                dup_cnt_q <= dup_cnt_q + CNT_W'(1);
            end else begin
                orig_cnt_q <= orig_cnt_q + CNT_W'(1);
            end
        end
    end

    // FSM and error latch state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            last_chk_q <= '0;
            prev_chk_q <= '0;
            pass_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            err_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            last_chk_q <= last_chk_d;
            prev_chk_q <= prev_chk_d;
            pass_q     <= pass_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            err_idx_q  <= err_idx_d;
        end
    end

    // Next-state: trigger at sync points, walk pairs 1..15, abort on any commit, halt on error
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        last_chk_d = last_chk_q;
        prev_chk_d = prev_chk_q;
        pass_d     = 1'b0;
        err_d      = err_q;
        err_code_d = err_code_q;
        err_idx_d  = err_idx_q;

        case (state_q)
            ST_IDLE: begin
                if (check_en && !commit_valid && (orig_cnt_q == dup_cnt_q) &&
                    (orig_cnt_q != last_chk_q)) begin
                    state_d    = ST_SCAN;
                    prev_chk_d = last_chk_q;
                    last_chk_d = orig_cnt_q;
                    idx_d      = 4'd1;
                end
            end
            ST_SCAN: begin
                if (commit_valid) begin
                    // State moved under the scan; forget this sync point so it can retrigger
                    state_d    = ST_IDLE;
                    last_chk_d = prev_chk_q;
                end else if (mismatch) begin
                    state_d    = ST_HALT;
                    err_d      = 1'b1;
                    err_code_d = ERR_MISMATCH;
                    err_idx_d  = idx_q;
                end else if (idx_q == 4'd15) begin
                    state_d = ST_IDLE;
                    pass_d  = 1'b1;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            ST_HALT: begin
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Partition violations take priority and freeze the checker
        if (violation && (state_q != ST_HALT)) begin
            state_d    = ST_HALT;
            pass_d     = 1'b0;
            err_d      = 1'b1;
            err_code_d = ERR_PARTITION;
            err_idx_d  = wb_rd[3:0];
        end
    end

    assign check_busy = (state_q == ST_SCAN);
    assign check_pass = pass_q;
    assign qed_error  = err_q;
    assign err_code   = err_code_q;
    assign err_idx    = err_idx_q;

endmodule

// File: doc/qed_consistency_checker.md
# qed_consistency_checker

Observes retired instructions from the core under QED. Keeps shadow copies of the original register half (x1–x15) and the duplicate half (x17–x31). Whenever the committed original and duplicate instruction counts match, it scans all 15 register pairs and compares them. It is the checking end of the QED transform: the instruction modifier maps `rd`/`rs` to `{1'b1, r[3:0]}`, and this block confirms that both halves reached identical architectural state.

## Interface
Parameters:
- `XLEN`, 32: register data width.
- `CNT_W`, 16: width of the committed-instruction counters.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `commit_valid`  in  1: one instruction retires this cycle.
- `commit_is_dup`  in  1: the retiring instruction is a QED duplicate.
- `wb_we`  in  1: the retiring instruction writes a register. Qualified by `commit_valid`.
- `wb_rd`  in  5: destination register.
- `wb_data`  in  XLEN: writeback value.
- `check_en`  in  1: enables triggering of new checks.
- `check_busy`  out  1: high while a scan is in progress.
- `check_pass`  out  1: one-cycle pulse when a scan completes with all pairs equal.
- `qed_error`  out  1: sticky error flag.
- `err_code`  out  2: error type. 01 = value mismatch, 10 = partition violation.
- `err_idx`  out  4: pair index (1–15) for a mismatch, or `wb_rd[3:0]` for a violation.

## Operation
- **Shadow write.** A write happens when `commit_valid && wb_we && wb_rd != 0`.
  - `wb_rd[4]=0` writes `orig[wb_rd[3:0]]`; `wb_rd[4]=1` writes `dup[wb_rd[3:0]]`.
  - The write is never blocked, including during a scan.
- **Partition violation.** Any of the following, on a write, sets `qed_error` with `err_code=10` and `err_idx=wb_rd[3:0]`:
  - `wb_rd == 16`;
  - `wb_rd[4] != commit_is_dup`.
- **Counters.**
  - `orig_cnt` increments on `commit_valid && !commit_is_dup`.
  - `dup_cnt` increments on `commit_valid && commit_is_dup`.
  - Both wrap modulo 2^CNT_W; equality comparison stays valid across the wrap.
- **FSM states:** IDLE, SCAN, HALT.
- **IDLE → SCAN.** Taken when all of the following hold; `last_chk` then captures `orig_cnt` and `idx` is set to 1:
  - `check_en`;
  - `!commit_valid`;
  - `orig_cnt == dup_cnt`;
  - `orig_cnt != last_chk`.
- **SCAN.** Compares `orig[idx]` with `dup[idx]`, one pair per cycle, `idx` running 1..15.
  - **Mismatch:** latch `err_code=01` and `err_idx=idx`, set `qed_error`, go to HALT.
  - **idx == 15, equal:** pulse `check_pass`, go to IDLE.
  - **`commit_valid` high in any SCAN cycle:** abort to IDLE with no pass and no error. That cycle's pair is not evaluated. `last_chk` is restored to its pre-scan value, so the check can retrigger.
- **HALT.** Terminal state; left only by reset.
  - Any error, including a partition violation raised from IDLE or SCAN, forces HALT.
  - Shadows and counters continue updating; no further checks run.
- **Simultaneous events.** If a partition violation and a mismatch occur in the same cycle, the violation wins for `err_code`/`err_idx`.

## Timing
- **Reset values:** shadows 0, `orig_cnt = dup_cnt = last_chk = 0`, state IDLE, all outputs 0. Because `last_chk = 0` matches the counters, no check fires immediately after reset.
- **Shadow and counter updates** are visible on the edge after the commit.
- **Check latency:**
  - Trigger condition seen in IDLE at cycle T.
  - `check_busy` is high for cycles T+1..T+15, comparing idx 1..15.
  - `check_pass` is high in cycle T+16, state IDLE.
- **Mismatch at pair k:** `qed_error`, `err_code` and `err_idx` become valid in cycle T+k+1 and stay constant until reset.
- **Violation:** flagged on the edge after the offending commit.
- **Asynchronous reset mid-scan:** immediately returns to reset values; no pulse is emitted.

## Structure
- **`qed_pkg`:**
  - FSM state enum;
  - `ERR_MISMATCH`/`ERR_PARTITION` codes;
  - `QED_HALF_REGS = 16`;
  - the `dup_reg(r) = {1'b1, r[3:0]}` mapping constant.
- **Sub-module `qed_shadow_regfile`:**
  - two 15-entry XLEN arrays with one write port;
  - one indexed compare port outputting `orig[idx] != dup[idx]`.
- **Top level:** FSM, counters, error latch.

## Test plan
- **Clean pass:** commit orig `x5 = 0xDEADBEEF`, then dup `x21 = 0xDEADBEEF` (`commit_is_dup=1`), `check_en=1` → `check_busy` high for 15 cycles, then `check_pass` pulse; `qed_error=0`.
- **Mismatch:** commit orig `x3 = 7`, dup `x19 = 8`, then idle → `qed_error=1`, `err_code=01`, `err_idx=3` in cycle T+4; state HALT, and no pass on later equal counts.
- **Partition violation:** `commit_valid`, `commit_is_dup=0`, `wb_we`, `wb_rd=20` → next edge `qed_error=1`, `err_code=10`, `err_idx=4`.
- **Abort:** trigger a scan, then raise `commit_valid` (orig, no write) in SCAN cycle 6 → state returns to IDLE, no `check_pass`. Commit a matching dup → check retriggers and passes.
- **No retrigger:** after a pass, hold inputs idle for 50 cycles → no further `check_busy`. A write to `x0` must not alter any shadow.
- **Reset mid-scan:** assert `rst_n=0` at scan cycle 8 → all outputs 0 immediately; after release, the counters are 0 and no check occurs.
